// File: rtl/io_bus_arbiter_if.sv
// Signal bundle between the two IO bus masters, the arbiter and the IO slave chain.
interface io_bus_arbiter_if #(
  parameter int unsigned ADR_W = 14
);

  // Master 0: CPU load/store unit
  logic             m0_req;
  logic             m0_we;
  logic [ADR_W-1:0] m0_adr;
  logic [31:0]      m0_wdata;
  logic             m0_gnt;
  logic             m0_rvalid;
  logic [31:0]      m0_rdata;

  // Master 1: UART debug loader / DMA
  logic             m1_req;
  logic             m1_we;
  logic [ADR_W-1:0] m1_adr;
  logic [31:0]      m1_wdata;
  logic             m1_gnt;
  logic             m1_rvalid;
  logic [31:0]      m1_rdata;

  // Chained IO register bus
  logic             dma_io_we;
  logic [ADR_W-1:0] dma_io_wadr;
  logic [31:0]      dma_io_wdata;
  logic [ADR_W-1:0] dma_io_radr;
  logic             dma_io_radr_en;
  logic [31:0]      dma_io_rdata;

  // Everything the arbiter does not drive: both masters plus the slave chain
  modport master (
    output m0_req, m0_we, m0_adr, m0_wdata,
    output m1_req, m1_we, m1_adr, m1_wdata,
    output dma_io_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
  );

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wdata,
    input  m1_req, m1_we, m1_adr, m1_wdata,
    input  dma_io_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
  );

endinterface

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the chained IO register bus: one single-beat command
// per cycle, registered onto the bus, read data routed back two cycles after grant.
module io_bus_arbiter #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned ADR_W = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  io_bus_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [31:0]      wdata;
    owner_e           owner;
  } cmd_t;

  typedef struct packed {
    logic   v;
    owner_e owner;
  } rd_t;

  owner_e last_gnt;
  owner_e last_gnt_nxt;
  cmd_t   cmd_q;
  cmd_t   cmd_nxt;
  rd_t    rd_q;
  rd_t    rd_nxt;
  logic   gnt0_c;
  logic   gnt1_c;
  logic   rvalid0;
  logic   rvalid1;

  // Pick at most one winner this cycle; contention goes to whoever did not win last
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      if (RR_EN && (last_gnt == OWN_M1)) begin
        gnt0_c = 1'b1;
      end else begin
        gnt1_c = 1'b1;
      end
    end else begin
      gnt0_c = bus.m0_req;
      gnt1_c = bus.m1_req;
    end
  end

  // Next command stage, return stage and grant history
  always_comb begin
    last_gnt_nxt = last_gnt;
    cmd_nxt      = '0;
    rd_nxt       = '0;
    rd_nxt.v     = cmd_q.v & ~cmd_q.we;
    rd_nxt.owner = cmd_q.owner;
    if (gnt0_c) begin
      last_gnt_nxt  = OWN_M0;
      cmd_nxt.v     = 1'b1;
      cmd_nxt.we    = bus.m0_we;
      cmd_nxt.adr   = bus.m0_adr;
      cmd_nxt.wdata = bus.m0_we ? bus.m0_wdata : 32'h0;
      cmd_nxt.owner = OWN_M0;
    end else if (gnt1_c) begin
      last_gnt_nxt  = OWN_M1;
      cmd_nxt.v     = 1'b1;
      cmd_nxt.we    = bus.m1_we;
      cmd_nxt.adr   = bus.m1_adr;
      cmd_nxt.wdata = bus.m1_we ? bus.m1_wdata : 32'h0;
      cmd_nxt.owner = OWN_M1;
    end
  end

  // Pipeline registers; reset discards any in-flight command or pending read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWN_M1;
      cmd_q    <= '0;
      rd_q     <= '0;
    end else begin
      last_gnt <= last_gnt_nxt;
      cmd_q    <= cmd_nxt;
      rd_q     <= rd_nxt;
    end
  end

  // Grants are same-cycle handshakes back to the masters
  assign bus.m0_gnt = gnt0_c;
  assign bus.m1_gnt = gnt1_c;

  // Bus strobes straight from the command stage; idle/read fields are already zero
  assign bus.dma_io_we      = cmd_q.v & cmd_q.we;
  assign bus.dma_io_radr_en = cmd_q.v & ~cmd_q.we;
  assign bus.dma_io_wadr    = cmd_q.adr;
  assign bus.dma_io_radr    = cmd_q.adr;
  assign bus.dma_io_wdata   = cmd_q.wdata;

  // Return path: slave data is steered to the owner of the read, zero otherwise
  assign rvalid0 = rd_q.v & (rd_q.owner == OWN_M0);
  assign rvalid1 = rd_q.v & (rd_q.owner == OWN_M1);

  assign bus.m0_rvalid = rvalid0;
  assign bus.m1_rvalid = rvalid1;
  assign bus.m0_rdata  = rvalid0 ? bus.dma_io_rdata : 32'h0;
  assign bus.m1_rdata  = rvalid1 ? bus.dma_io_rdata : 32'h0;

endmodule
